// File: rtl/ultrasonic_scan_ctrl.sv
// ultrasonic_scan_ctrl
//   Round-robin sequencer for up to N_SENS HC-SR04 style range sensors that
//   share one echo-timing datapath. For each sensor in turn it fires a
//   trigger pulse, waits for the echo rising edge, measures the echo width,
//   supervises a timeout, reports one tagged result and holds a quiet gap.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   enable     in   1 = keep scanning, 0 = stop after the current shot
//   echo       in   raw echo lines (asynchronous to clk)
//   trig       out  trigger lines, at most one bit high
//   dist_data  out  echo width in clk cycles (0 on timeout), held until next report
//   dist_sel   out  sensor index of the reported shot
//   dist_valid out  one-cycle result strobe
//   timeout    out  qualifies dist_valid; held until next report
//   busy       out  high whenever the sequencer is not idle
module ultrasonic_scan_ctrl #(
   parameter int unsigned N_SENS      = 4,
   parameter int unsigned SEL_W       = 2,
   parameter int unsigned CNT_W       = 22,
   parameter int unsigned TRIG_CYC    = 1000,
   parameter int unsigned TIMEOUT_CYC = 3000000,
   parameter int unsigned GAP_CYC     = 2000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [N_SENS-1:0] echo,
   output logic [N_SENS-1:0] trig,
   output logic [CNT_W-1:0]  dist_data,
   output logic [SEL_W-1:0]  dist_sel,
   output logic              dist_valid,
   output logic              timeout,
   output logic              busy
);

   // Phase timer shared by the trigger pulse and the quiet gap.
   localparam int unsigned PHASE_MAX = (TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC;
   localparam int unsigned TMR_W     = $clog2(PHASE_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      REPORT,
      GAP
   } state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [N_SENS-1:0]   echo_s1_q, echo_s2_q;
   logic [CNT_W-1:0]    width_q, width_d;
   logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                seen_low_q, seen_low_d;

   logic [N_SENS-1:0]   trig_q, trig_d;
   logic [CNT_W-1:0]    dist_data_q, dist_data_d;
   logic [SEL_W-1:0]    dist_sel_q, dist_sel_d;
   logic                dist_valid_q, dist_valid_d;
   logic                timeout_q, timeout_d;
   logic                busy_q, busy_d;

   logic                echo_cur;
   logic [CNT_W-1:0]    tmo_inc;
   logic                tmo_hit;
   logic                report_tmo;

   // Two-stage synchroniser on every echo line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         echo_s1_q <= '0;
         echo_s2_q <= '0;
      end else begin
         echo_s1_q <= echo;
         echo_s2_q <= echo_s1_q;
      end
   end

   // Only the selected sensor's synchronised echo is observed.
   always_comb begin
      echo_cur = 1'b0;
      for (int unsigned i = 0; i < N_SENS; i++) begin
         if (sel_q == SEL_W'(i)) begin
            echo_cur = echo_s2_q[i];
         end
      end
   end

   assign tmo_inc = tmo_cnt_q + CNT_W'(1);
   assign tmo_hit = (tmo_inc == CNT_W'(TIMEOUT_CYC));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         width_q      <= '0;
         tmo_cnt_q    <= '0;
         tmr_q        <= '0;
         seen_low_q   <= 1'b0;
         trig_q       <= '0;
         dist_data_q  <= '0;
         dist_sel_q   <= '0;
         dist_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         width_q      <= width_d;
         tmo_cnt_q    <= tmo_cnt_d;
         tmr_q        <= tmr_d;
         seen_low_q   <= seen_low_d;
         trig_q       <= trig_d;
         dist_data_q  <= dist_data_d;
         dist_sel_q   <= dist_sel_d;
         dist_valid_q <= dist_valid_d;
         timeout_q    <= timeout_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      width_d    = width_q;
      tmo_cnt_d  = tmo_cnt_q;
      tmr_d      = tmr_q;
      seen_low_d = seen_low_q;
      report_tmo = 1'b0;

      case (state_q)
         IDLE: begin
            width_d   = '0;
            tmo_cnt_d = '0;
            tmr_d     = '0;
            if (enable) begin
               state_d = TRIG;
            end
         end

         TRIG: begin
            if (tmr_q == TMR_W'(TRIG_CYC - 1)) begin
               state_d    = WAIT_RISE;
               tmr_d      = '0;
               seen_low_d = 1'b0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         // A rising edge needs a low sample first, so an echo already high
         // on entry must fall and rise again before it counts.
         WAIT_RISE: begin
            tmo_cnt_d = tmo_inc;
            if (tmo_hit) begin
               state_d    = REPORT;
               report_tmo = 1'b1;
            end else if (echo_cur && seen_low_q) begin
               state_d = MEASURE;
               width_d = CNT_W'(1);
            end else if (!echo_cur) begin
               seen_low_d = 1'b1;
            end
         end

         MEASURE: begin
            tmo_cnt_d = tmo_inc;
            if (tmo_hit) begin
               state_d    = REPORT;
               report_tmo = 1'b1;
            end else if (!echo_cur) begin
               state_d = REPORT;
            end else if (width_q != '1) begin
               width_d = width_q + CNT_W'(1);
            end
         end

         REPORT: begin
            state_d = GAP;
            tmr_d   = '0;
         end

         GAP: begin
            if (tmr_q == TMR_W'(GAP_CYC - 1)) begin
               state_d = IDLE;
               tmr_d   = '0;
               sel_d   = (sel_q == SEL_W'(N_SENS - 1)) ? '0 : sel_q + SEL_W'(1);
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so each one is aligned with
   // the state it belongs to and comes straight from a flop.
   always_comb begin
      dist_valid_d = (state_d == REPORT);
      dist_data_d  = dist_data_q;
      dist_sel_d   = dist_sel_q;
      timeout_d    = timeout_q;
      busy_d       = (state_d != IDLE);
      if (state_d == REPORT) begin
         dist_data_d = report_tmo ? '0 : width_q;
         dist_sel_d  = sel_q;
         timeout_d   = report_tmo;
      end
      for (int unsigned i = 0; i < N_SENS; i++) begin
         trig_d[i] = (state_d == TRIG) && (sel_q == SEL_W'(i));
      end
   end

   assign trig       = trig_q;
   assign dist_data  = dist_data_q;
   assign dist_sel   = dist_sel_q;
   assign dist_valid = dist_valid_q;
   assign timeout    = timeout_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Testbench for ultrasonic_scan_ctrl: randomized echo stimulus per shot, with
// the expected per-cycle trig/busy/report behaviour derived from the shot
// timeline (trigger length, echo delay and width, timeout and gap lengths).
module tb_ultrasonic_scan_ctrl;

   localparam int N_SENS  = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 12;
   localparam int TRIG    = 10;
   localparam int TMO     = 500;
   localparam int GAP     = 20;

   localparam int K_PULSE  = 0;
   localparam int K_NONE   = 1;
   localparam int K_GLITCH = 2;
   localparam int K_STUCK  = 3;

   logic              clk;
   logic              reset;
   logic              enable;
   logic [N_SENS-1:0] echo;
   logic [N_SENS-1:0] trig;
   logic [CNT_W-1:0]  dist_data;
   logic [SEL_W-1:0]  dist_sel;
   logic              dist_valid;
   logic              timeout;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int exp_sel;
   int last_data;
   int last_tmo;
   int last_tol;

   ultrasonic_scan_ctrl #(
      .N_SENS      (N_SENS),
      .SEL_W       (SEL_W),
      .CNT_W       (CNT_W),
      .TRIG_CYC    (TRIG),
      .TIMEOUT_CYC (TMO),
      .GAP_CYC     (GAP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .echo       (echo),
      .trig       (trig),
      .dist_data  (dist_data),
      .dist_sel   (dist_sel),
      .dist_valid (dist_valid),
      .timeout    (timeout),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input longint obs, input longint exp,
                        input longint tol = 0);
      n_checks++;
      if (obs < exp - tol || obs > exp + tol) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d, expected %0d (tol %0d)", tag, $time, obs, exp, tol);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_trig"},  trig,       0);
      check({tag, "_busy"},  busy,       0);
      check({tag, "_valid"}, dist_valid, 0);
      check({tag, "_data"},  dist_data,  0);
      check({tag, "_sel"},   dist_sel,   0);
      check({tag, "_tmo"},   timeout,    0);
   endtask

   function automatic logic [N_SENS-1:0] noise();
      return N_SENS'($urandom);
   endfunction

   // One complete shot starting with the first TRIG cycle (k = 0), ending
   // after the IDLE cycle that follows the gap. Checks are made mid-cycle.
   task automatic run_shot(input int kind, input int d, input int h, input bit drop_en);
      int s;
      int off;
      int exp_w;
      int exp_t;
      int r;
      logic [N_SENS-1:0] nv;
      s = exp_sel;
      if (kind == K_PULSE && (d + h + 3) < TMO) begin
         exp_t = 0;
         exp_w = h;
         off   = d + h + 3;
      end else begin
         exp_t = 1;
         exp_w = 0;
         off   = TMO;
      end
      r = TRIG + off;
      for (int k = 0; k <= r + GAP + 1; k++) begin
         @(negedge clk);
         check("trig",  trig,       (k < TRIG) ? (1 << s) : 0);
         check("busy",  busy,       (k <= r + GAP) ? 1 : 0);
         check("valid", dist_valid, (k == r) ? 1 : 0);
         if (k == r) begin
            check("sel", dist_sel, s);
            last_data = exp_w;
            last_tmo  = exp_t;
            last_tol  = exp_t ? 0 : 1;
         end
         check("data", dist_data, last_data, last_tol);
         check("tmo",  timeout,   last_tmo);

         nv = noise();
         case (kind)
            K_PULSE: nv[s] = (k >= TRIG + d) && (k < TRIG + d + h);
            K_STUCK: nv[s] = (k <= r);
            default: nv[s] = 1'b0;
         endcase
         echo = nv;
         if (kind == K_GLITCH && k == TRIG + d) begin
            #1 echo[s] = 1'b1;
            #1 echo[s] = 1'b0;
         end
         if (drop_en && k == TRIG + 2) enable = 1'b0;
      end
      exp_sel = (s + 1) % N_SENS;
   endtask

   task automatic idle_then_enable(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_trig",  trig,       0);
         check("idle_busy",  busy,       0);
         check("idle_valid", dist_valid, 0);
         echo = noise();
      end
      enable = 1'b1;
   endtask

   task automatic reset_mid_trig();
      int s;
      s = exp_sel;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rst_trig", trig, 1 << s);
         check("rst_busy", busy, 1);
         echo = '0;
      end
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      exp_sel   = 0;
      last_data = 0;
      last_tmo  = 0;
      last_tol  = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_all_zero("in_rst");
      end
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      echo   = '0;
      exp_sel   = 0;
      last_data = 0;
      last_tmo  = 0;
      last_tol  = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_all_zero("reset");
      end
      reset = 1'b0;

      run_shot(K_PULSE, 30, 100, 1'b0);                                         // s0
      run_shot(K_NONE, 0, 0, 1'b0);                                             // s1
      run_shot(K_PULSE, $urandom_range(1, 150), $urandom_range(1, 250), 1'b0);  // s2
      run_shot(K_PULSE, $urandom_range(1, 150), 1, 1'b0);                       // s3
      run_shot(K_GLITCH, $urandom_range(1, 200), 0, 1'b0);                      // s0
      run_shot(K_PULSE, $urandom_range(1, 150), $urandom_range(1, 250), 1'b0);  // s1
      run_shot(K_STUCK, 0, 0, 1'b1);                                            // s2, enable drops
      idle_then_enable(6);
      run_shot(K_PULSE, $urandom_range(1, 150), $urandom_range(1, 250), 1'b0);  // s3
      reset_mid_trig();
      for (int i = 0; i < 6; i++) begin
         int kind;
         kind = $urandom_range(0, 2);
         run_shot(kind, $urandom_range(1, 150), $urandom_range(1, 250), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ultrasonic_scan_ctrl.md
Name: ultrasonic_scan_ctrl

Overview:
- Sequences up to N ultrasonic range sensors (HC-SR04 style) that share one echo-timing datapath.
- Runs a round-robin schedule per sensor: trigger pulse generation, echo-width measurement, timeout supervision and inter-shot quiet gap.
- Emits one tagged result per shot.
- Sits between the sensor I/O pins and the distance-conversion/display logic of the ultrasound subsystem.

Parameters:
- N_SENS, 4, number of sensors scheduled (2..8).
- SEL_W, 2, width of the sensor index; must be at least ceil(log2(N_SENS)).
- CNT_W, 22, width of the echo-width and timeout counters.
- TRIG_CYC, 1000, trigger high time in clk cycles (10 us at 100 MHz).
- TIMEOUT_CYC, 3000000, maximum cycles from the end of the trigger to echo completion (30 ms).
- GAP_CYC, 2000000, quiet cycles after each shot before the next sensor fires (20 ms).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = keep scanning, 0 = stop after the current shot.
- echo  in  N_SENS  raw echo lines, asynchronous to clk.
- trig  out  N_SENS  trigger lines; at most one bit high at any time.
- dist_data  out  CNT_W  echo high width in clk cycles for the reported shot.
- dist_sel  out  SEL_W  sensor index of the reported shot.
- dist_valid  out  1  one-cycle strobe; dist_data, dist_sel and timeout are valid in this cycle.
- timeout  out  1  qualifies dist_valid; 1 = no valid echo within TIMEOUT_CYC.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; sel = 0.
  - trig, dist_data, dist_sel, dist_valid, timeout and busy are all 0.
  - Both counters and both synchroniser stages are cleared.
  - trig drops in the same instant reset asserts, even mid-pulse.
- Echo input: each echo bit passes a 2-FF synchroniser (echo_s). Only echo[sel] is observed; the other bits are ignored.
- States and transitions:
  - IDLE: if enable=1, go to TRIG next cycle and clear the counters.
  - TRIG: trig[sel]=1 for exactly TRIG_CYC cycles, then go to WAIT_RISE. enable is ignored in this state.
  - WAIT_RISE:
    - Requires an edge: echo_s must be sampled 0, then 1.
    - On the rising edge, go to MEASURE with the width counter at 1.
    - An echo already high on entry is not a rising edge; it must fall and rise again.
  - MEASURE: width counter increments each cycle echo_s=1 and saturates at all-ones. On the first cycle echo_s=0, go to REPORT.
  - Timeout counter:
    - Runs during every WAIT_RISE and MEASURE cycle.
    - When it reaches TIMEOUT_CYC, go to REPORT with timeout=1. This has priority over an echo edge in the same cycle.
  - REPORT (1 cycle):
    - dist_valid=1 and dist_sel=sel.
    - dist_data = width, or 0 if timeout.
    - timeout and dist_data hold their values until the next REPORT; dist_valid is high only here.
    - Next state: GAP.
  - GAP:
    - All trig low for GAP_CYC cycles.
    - Then sel = (sel == N_SENS-1) ? 0 : sel+1 (wrap-around) and go to IDLE.
- Latency:
  - A low-to-high echo pin edge is seen 2 cycles later.
  - dist_valid occurs 3 cycles after the echo pin falls (2 synchroniser cycles + 1 REPORT cycle).
  - Measured width = pin high time in cycles, ±1 cycle.
- enable deasserted mid-shot: the shot completes, including REPORT and GAP. The block then stays in IDLE with sel already advanced. Re-enable resumes from that sel.
- Boundaries:
  - Echo pulse longer than 2^CNT_W-1 cycles: the width saturates. REPORT is reached via timeout if TIMEOUT_CYC is exceeded first.
  - Zero-width glitch filtered by the synchroniser: treated as no echo.
  - An echo on a non-selected sensor never affects state.

Test Plan (override TRIG_CYC=10, TIMEOUT_CYC=500, GAP_CYC=20, N_SENS=4, CNT_W=12):
1. reset=1 with enable=1 -> all outputs 0, no trig. Release reset -> trig[0] high for exactly 10 cycles, busy=1.
2. echo[0] goes high 30 cycles after trig falls and stays high 100 cycles -> dist_valid once, dist_sel=0, dist_data=100±1, timeout=0. trig[1] rises 20 GAP cycles + 2 after REPORT (GAP→IDLE→TRIG).
3. No echo on sensor 1 -> REPORT exactly 500 cycles after trig[1] falls; timeout=1, dist_data=0, dist_sel=1.
4. Full scan of 4 shots -> dist_sel sequence 0,1,2,3,0. Only one trig bit is ever high. Pulses on non-selected echo lines are ignored.
5. echo[2] stuck high before TRIG -> timeout=1 report for sensor 2. enable dropped during that shot -> after GAP, IDLE with busy=0. Re-enable -> trig[3] fires next.
6. Assert reset 5 cycles into a trig pulse -> trig drops immediately, state IDLE, sel=0. After release, the scan restarts at sensor 0.
